// File: rtl/hazard3_fetch_align.sv
// Fetch alignment buffer: turns a stream of word-aligned fetch data into a
// stream of aligned instructions, expanding RVC encodings on the way out.

module hazard3_instr_decompress #(
  parameter int PASSTHROUGH = 0
) (
  input  logic [31:0] instr_in,
  output logic [31:0] instr_out,
  output logic        is_32bit,
  output logic        invalid
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_OP};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd0, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p, rs2p;
  logic [11:0] imm_ci, imm_lw, imm_4spn, imm_16sp, imm_lwsp, imm_swsp;
  logic [20:0] joff;
  logic [12:0] boff;

  assign c    = instr_in[15:0];
  assign rd   = c[11:7];
  assign rs2  = c[6:2];
  assign rdp  = {2'b01, c[4:2]};
  assign rs1p = {2'b01, c[9:7]};
  assign rs2p = {2'b01, c[4:2]};

  // Immediate scrambles of the various CI/CL/CS/CSS/CIW/CJ/CB formats
  assign imm_ci   = {{7{c[12]}}, c[6:2]};
  assign imm_lw   = {5'b0, c[5], c[12:10], c[6], 2'b00};
  assign imm_4spn = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign imm_16sp = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
  assign imm_lwsp = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
  assign imm_swsp = {4'b0, c[8:7], c[12:9], 2'b00};
  assign joff     = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
  assign boff     = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};

  always_comb begin
    instr_out = {16'h0000, c};
    is_32bit  = 1'b0;
    invalid   = 1'b0;
    if (PASSTHROUGH != 0 || c[1:0] == 2'b11) begin
      instr_out = instr_in;
      is_32bit  = 1'b1;
    end else begin
      case (c[1:0])
        2'b00: begin
          case (c[15:13])
            3'b000: begin
              instr_out = enc_i(imm_4spn, 5'd2, 3'b000, rdp, OP_IMM);
              invalid   = (imm_4spn == 12'd0);
            end
            3'b010:  instr_out = enc_i(imm_lw, rs1p, 3'b010, rdp, OP_LOAD);
            3'b110:  instr_out = enc_s(imm_lw, rs2p, rs1p, 3'b010);
            default: invalid = 1'b1;
          endcase
        end
        2'b01: begin
          case (c[15:13])
            3'b000: instr_out = enc_i(imm_ci, rd, 3'b000, rd, OP_IMM);
            3'b001: instr_out = enc_j(joff, 5'd1);
            3'b010: instr_out = enc_i(imm_ci, 5'd0, 3'b000, rd, OP_IMM);
            3'b011: begin
              if (rd == 5'd2) begin
                instr_out = enc_i(imm_16sp, 5'd2, 3'b000, 5'd2, OP_IMM);
                invalid   = (imm_16sp == 12'd0);
              end else begin
                instr_out = {{15{c[12]}}, c[6:2], rd, OP_LUI};
                invalid   = !c[12] && (c[6:2] == 5'd0);
              end
            end
            3'b100: begin
              case (c[11:10])
                2'b00: begin
                  instr_out = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                  invalid   = c[12];
                end
                2'b01: begin
                  instr_out = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                  invalid   = c[12];
                end
                2'b10: instr_out = enc_i(imm_ci, rs1p, 3'b111, rs1p, OP_IMM);
                default: begin
                  // c[12] set here selects the RV64-only word ops
                  invalid = c[12];
                  case (c[6:5])
                    2'b00:   instr_out = enc_r(7'b0100000, rs2p, rs1p, 3'b000, rs1p);
                    2'b01:   instr_out = enc_r(7'b0000000, rs2p, rs1p, 3'b100, rs1p);
                    2'b10:   instr_out = enc_r(7'b0000000, rs2p, rs1p, 3'b110, rs1p);
                    default: instr_out = enc_r(7'b0000000, rs2p, rs1p, 3'b111, rs1p);
                  endcase
                end
              endcase
            end
            3'b101:  instr_out = enc_j(joff, 5'd0);
            3'b110:  instr_out = enc_b(boff, rs1p, 3'b000);
            default: instr_out = enc_b(boff, rs1p, 3'b001);
          endcase
        end
        2'b10: begin
          case (c[15:13])
            3'b000: begin
              instr_out = {7'b0000000, c[6:2], rd, 3'b001, rd, OP_IMM};
              invalid   = c[12];
            end
            3'b010: begin
              instr_out = enc_i(imm_lwsp, 5'd2, 3'b010, rd, OP_LOAD);
              invalid   = (rd == 5'd0);
            end
            3'b100: begin
              if (!c[12]) begin
                if (rs2 == 5'd0) begin
                  instr_out = enc_i(12'd0, rd, 3'b000, 5'd0, OP_JALR);
                  invalid   = (rd == 5'd0);
                end else begin
                  instr_out = enc_r(7'b0000000, rs2, 5'd0, 3'b000, rd);
                end
              end else if (rs2 == 5'd0) begin
                if (rd == 5'd0) instr_out = 32'h0010_0073;
                else            instr_out = enc_i(12'd0, rd, 3'b000, 5'd1, OP_JALR);
              end else begin
                instr_out = enc_r(7'b0000000, rs2, rd, 3'b000, rd);
              end
            end
            3'b110:  instr_out = enc_s(imm_swsp, rs2, 5'd2, 3'b010);
            default: invalid = 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

module hazard3_fetch_align #(
  parameter int PASSTHROUGH  = 0,
  parameter int BUF_DEPTH_HW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        fetch_err,
  input  logic        flush,
  input  logic        flush_addr_bit1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_is_32bit,
  output logic        out_invalid,
  output logic        out_err
);

  localparam int DEPTH = BUF_DEPTH_HW;

  logic [DEPTH-1:0][15:0] buf_hw, buf_hw_nxt;
  logic [DEPTH-1:0]       buf_err, buf_err_nxt;
  logic [2:0]             level, level_nxt, level_pop;
  logic                   discard;

  logic        head_32, has_one, has_two;
  logic        handshake, fetch_accept;
  logic [1:0]  pop_hw, app_hw, wr_idx0, wr_idx1;
  logic        dec_invalid;

  assign head_32 = (PASSTHROUGH != 0) || (buf_hw[0][1:0] == 2'b11);
  assign has_one = (level != 3'd0);
  assign has_two = (level >= 3'd2);

  assign fetch_ready  = (level <= 3'd2) && !flush;
  assign fetch_accept = fetch_valid && fetch_ready;

  // An errored hw0 is presented on its own even if it claims to be 32-bit
  assign out_valid = !flush && has_one && (!head_32 || has_two || buf_err[0]);
  assign out_err   = has_one && (buf_err[0] || (head_32 && has_two && buf_err[1]));
  assign handshake = out_valid && out_ready;

  hazard3_instr_decompress #(
    .PASSTHROUGH (PASSTHROUGH)
  ) u_decomp (
    .instr_in  ({buf_hw[1], buf_hw[0]}),
    .instr_out (out_instr),
    .is_32bit  (out_is_32bit),
    .invalid   (dec_invalid)
  );

  assign out_invalid = dec_invalid && !out_err;

  always_comb begin
    pop_hw = 2'd0;
    if (handshake) pop_hw = (head_32 && has_two) ? 2'd2 : 2'd1;
  end

  always_comb begin
    app_hw = 2'd0;
    if (fetch_accept) app_hw = discard ? 2'd1 : 2'd2;
  end

  assign level_pop = level - {1'b0, pop_hw};
  assign level_nxt = level_pop + {1'b0, app_hw};
  assign wr_idx0   = level_pop[1:0];
  assign wr_idx1   = wr_idx0 + 2'd1;

  // Head stays at index 0: pop by shifting down, append just above what remains
  always_comb begin
    buf_hw_nxt  = buf_hw >> {pop_hw, 4'b0000};
    buf_err_nxt = buf_err >> pop_hw;
    if (fetch_accept) begin
      if (discard) begin
        buf_hw_nxt[wr_idx0]  = fetch_data[31:16];
        buf_err_nxt[wr_idx0] = fetch_err;
      end else begin
        buf_hw_nxt[wr_idx0]  = fetch_data[15:0];
        buf_err_nxt[wr_idx0] = fetch_err;
        buf_hw_nxt[wr_idx1]  = fetch_data[31:16];
        buf_err_nxt[wr_idx1] = fetch_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= 3'd0;
      discard <= 1'b0;
    end else if (flush) begin
      level   <= 3'd0;
      discard <= flush_addr_bit1;
    end else begin
      level <= level_nxt;
      if (fetch_accept) discard <= 1'b0;
    end
  end

  // Buffer contents are only meaningful below level, so they carry no reset
  always_ff @(posedge clk) begin
    buf_hw  <= buf_hw_nxt;
    buf_err <= buf_err_nxt;
  end

endmodule
